// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed 32-bit multiply/divide coprocessor.
// A ctrl_MULT or ctrl_DIV pulse captures both operands. The block then runs
// 32 iterations: shift-add for a multiply, or restoring division for a divide.
// It registers the signed result and the exception flag, and pulses
// data_resultRDY for one cycle.
//
// Ports
//   clock          : system clock, rising edge
//   reset          : asynchronous active-low reset
//   data_operandA  : multiplicand / dividend (two's complement)
//   data_operandB  : multiplier / divisor (two's complement)
//   ctrl_MULT      : start multiply (wins over ctrl_DIV)
//   ctrl_DIV       : start divide
//   data_result    : product low word or quotient, held until the next result
//   data_exception : multiply overflow or divide error, held with data_result
//   data_resultRDY : one-cycle pulse when data_result becomes valid
//   busy           : operation in flight
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a start
// RUN   | one iteration per edge; result registered when count = 31
// DONE  | single cycle with data_resultRDY = 1
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  logic                 start;
  logic                 last;
  logic                 op_mult;
  logic                 neg;
  logic                 div_err;
  logic [WIDTH-1:0]     opnd;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc;        // {upper, multiplier} or {remainder, quotient}
  logic [CW-1:0]        count;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH-1:0]     div_sh;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   iter_next;
  logic [2*WIDTH-1:0]   prod_s;
  logic                 mul_exc;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     fin_result;
  logic                 fin_exc;

  assign start = ctrl_MULT | ctrl_DIV;
  assign last  = (count == CW'(WIDTH-1));

  // The most negative value negates to itself, which is also its correct
  // unsigned magnitude.
  assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Shift-add step. The carry out of the upper-half add shifts into bit 63.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring step. The remainder always stays below the divisor (<= 2^31).
  // Its top bit is therefore zero, and the shifted remainder fits in WIDTH bits.
  assign div_sh   = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
  assign div_diff = {1'b0, div_sh} - {1'b0, opnd};
  assign div_next = div_diff[WIDTH]
                  ? {div_sh, acc[WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign iter_next = op_mult ? mul_next : div_next;

  // Final sign fix-up, applied to the value of the 32nd iteration.
  assign prod_s  = neg ? -iter_next : iter_next;
  assign mul_exc = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
  assign quo_s   = neg ? -iter_next[WIDTH-1:0] : iter_next[WIDTH-1:0];

  always_comb begin
    fin_result = '0;
    fin_exc    = 1'b0;
    if (op_mult) begin
      fin_result = prod_s[WIDTH-1:0];
      fin_exc    = mul_exc;
    end else if (div_err) begin
      fin_result = '0;
      fin_exc    = 1'b1;
    end else begin
      fin_result = quo_s;
      fin_exc    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (start)     state_nxt = S_RUN;
        else if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        data_resultRDY = 1'b1;
        state_nxt      = start ? S_RUN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_mult        <= 1'b0;
      neg            <= 1'b0;
      div_err        <= 1'b0;
      opnd           <= '0;
      acc            <= '0;
      count          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      op_mult <= ctrl_MULT;
      neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_err <= (data_operandB == '0) ||
                 ((data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB));
      opnd    <= ctrl_MULT ? mag_a : mag_b;
      acc     <= {{WIDTH{1'b0}}, (ctrl_MULT ? mag_b : mag_a)};
      count   <= '0;
    end else if (state == S_RUN) begin
      acc   <= iter_next;
      count <= count + CW'(1);
      if (last) begin
        data_result    <= fin_result;
        data_exception <= fin_exc;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
module tb_multdiv_iter;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int vectors;
  int miscompares;

  multdiv_iter #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: plain signed arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input bit is_mult,
                                output logic [31:0] r, output logic e);
    longint p;
    int     q;
    if (is_mult) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
      r = 32'd0;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
  endfunction

  // Leaves the bench 1 time unit after the capture edge E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input bit m, input bit d);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Called right after start_op. Returns 1 time unit after the edge that
  // raised RDY, so a following start_op lands on the DONE cycle.
  task automatic wait_result(input logic [31:0] er, input logic ee, input string name);
    int          cyc;
    bit          busy_bad;
    bit          early;
    logic [31:0] held_r;
    logic        held_e;
    cyc      = 0;
    busy_bad = 0;
    early    = 0;
    held_r   = data_result;
    held_e   = data_exception;
    while (cyc < 40 && data_resultRDY !== 1'b1) begin
      if (busy !== 1'b1) busy_bad = 1;
      if (data_result !== held_r || data_exception !== held_e) early = 1;
      @(posedge clock);
      #1;
      cyc++;
    end
    vectors++;
    if (cyc !== 32) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles, expected 32", name, cyc);
    end
    vectors++;
    if (busy_bad || early) begin
      miscompares++;
      $display("FAIL %s run: busy_low=%0d result_changed_early=%0d, expected 0 0", name, busy_bad, early);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy in done: got %b, expected 0", name, busy);
    end
    vectors++;
    if (data_result !== er || data_exception !== ee) begin
      miscompares++;
      $display("FAIL %s result: got %h exc %b, expected %h exc %b",
               name, data_result, data_exception, er, ee);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset outputs: got %h %b %b %b, expected all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
    @(negedge clock);
    reset = 1'b1;
    data_operandA = 32'h1234_5678;
    data_operandB = 32'h9;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      miscompares++;
      $display("FAIL idle ignores operands: got %h %b %b %b, expected all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
  endtask

  task automatic test_mult_directed();
    start_op(32'd7, 32'hFFFF_FFFD, 1, 0);
    wait_result(32'hFFFF_FFEB, 1'b0, "mult 7x-3");
    @(posedge clock);
    #1;
    vectors++;
    if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== 32'hFFFF_FFEB) begin
      miscompares++;
      $display("FAIL rdy fall: got rdy %b busy %b res %h, expected 0 0 ffffffeb",
               data_resultRDY, busy, data_result);
    end
    start_op(32'h0001_0000, 32'h0001_0000, 1, 0);
    wait_result(32'h0, 1'b1, "mult overflow");
    start_op(32'hFFFF_8000, 32'h0001_0000, 1, 0);
    wait_result(32'h8000_0000, 1'b0, "mult min edge");
  endtask

  task automatic test_div_directed();
    start_op(32'hFFFF_FFF9, 32'd2, 0, 1);
    wait_result(32'hFFFF_FFFD, 1'b0, "div -7/2");
    start_op(32'd5, 32'd0, 0, 1);
    wait_result(32'h0, 1'b1, "div by zero");
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
    wait_result(32'h0, 1'b1, "div overflow");
  endtask

  task automatic test_simultaneous();
    start_op(32'd6, 32'd3, 1, 1);
    wait_result(32'd18, 1'b0, "mult wins");
  endtask

  task automatic test_restart();
    bit seen;
    seen = 0;
    start_op(32'd100, 32'd7, 0, 1);
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) seen = 1;
    end
    start_op(32'd3, 32'd4, 1, 0);
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL restart early rdy: got rdy before restart, expected none");
    end
    wait_result(32'd12, 1'b0, "restart mult");
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    seen = 0;
    start_op(32'd123, 32'd45, 1, 0);
    repeat (14) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset mid run: got %h %b %b %b, expected all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1 || busy === 1'b1) seen = 1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL reset abort: got rdy/busy after reset, expected none");
    end
    start_op(32'd9, 32'd3, 0, 1);
    wait_result(32'd3, 1'b0, "div after reset");
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    logic [31:0] edges [6];
    edges = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h7FFF_FFFF, 32'h0001_0000};
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = $urandom_range(0, 200) - 100;
      2: begin v = $urandom; v = {{16{v[15]}}, v[15:0]}; end
      default: v = edges[$urandom_range(0, 5)];
    endcase
    return v;
  endfunction

  // Each op starts on the DONE cycle of the previous one.
  task automatic test_random_back_to_back();
    logic [31:0] a, b, er;
    logic        ee;
    bit          m;
    for (int i = 0; i < 40; i++) begin
      a = pick_operand();
      b = pick_operand();
      m = (i % 2 == 0);
      model(a, b, m, er, ee);
      vectors++;
      if (i > 0 && data_resultRDY !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b start in done: got rdy %b, expected 1", data_resultRDY);
      end
      start_op(a, b, m, !m);
      wait_result(er, ee, $sformatf("rand %0d %s %h %h", i, m ? "mul" : "div", a, b));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_mult_directed();
    test_div_directed();
    test_simultaneous();
    test_restart();
    test_reset_mid_run();
    test_random_back_to_back();
    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multdiv_iter.md
# multdiv_iter

Iterative signed 32-bit multiply/divide coprocessor that sits directly downstream of the execute stage. The execute stage pulses `ctrl_MULT` or `ctrl_DIV` with forwarded operands. This block runs a fixed-latency shift-add multiply or restoring divide. It then returns the result, an exception flag and a one-cycle ready pulse, which writeback uses to retire the operation and set rstatus.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported, and the iteration count equals `WIDTH`.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately when low.
- `data_operandA` in 32: multiplicand or dividend, two's complement.
- `data_operandB` in 32: multiplier or divisor, two's complement.
- `ctrl_MULT` in 1: start-multiply pulse, sampled on the rising edge.
- `ctrl_DIV` in 1: start-divide pulse, sampled on the rising edge.
- `data_result` out 32: product low word or quotient; held until the next start.
- `data_exception` out 1: overflow or divide error; held with `data_result`.
- `data_resultRDY` out 1: high for exactly one cycle when the result becomes valid.
- `busy` out 1: high while an operation is in flight (RUN state).

## Operation
- FSM states are IDLE, RUN and DONE. The reset state is IDLE, and all outputs are 0 at reset.
- **Start.**
  - If `ctrl_MULT` or `ctrl_DIV` is high at an edge in any state, the block latches both operands and the op type. It clears the counter and working registers and enters RUN.
  - If both controls are high, MULT wins.
  - A start during RUN aborts the current operation and restarts; no RDY is issued for the aborted op.
  - A start during DONE is legal; the result of the previous op stays visible during its RDY cycle.
- **Sign handling.**
  - Both operands are converted to magnitudes at capture.
  - Result sign = sign(A) XOR sign(B).
  - The final negation is applied on the RUN->DONE edge.
- **Multiply.**
  - Unsigned shift-add over 32 iterations using a 64-bit accumulator.
  - Each iteration: if multiplier LSB = 1, add the multiplicand to the upper half; then shift right by 1.
- **Divide.**
  - Unsigned restoring division over 32 iterations.
  - Each iteration: shift {remainder, quotient} left by 1, trial-subtract the divisor, and keep the subtraction if it is non-negative, setting the quotient bit.
  - Quotient truncates toward zero; the remainder is discarded.
- **Exceptions.**
  - Multiply: `data_exception` = 1 if the signed 64-bit product is outside [-2^31, 2^31-1]. `data_result` = the low 32 bits of the signed product (wrapped).
  - Divide with B = 0: `data_exception` = 1, `data_result` = 0.
  - Divide with A = 0x80000000 and B = 0xFFFFFFFF: `data_exception` = 1, `data_result` = 0.
  - Exception cases still take the full latency; no early exit.
- **DONE state.** Lasts exactly one cycle, with `data_resultRDY` = 1. The block then goes to IDLE, or to RUN if a start is present.
- **Idle behaviour.** Operand inputs are ignored except on a start edge.

## Timing
- Start sampled at edge E0 -> RUN with count = 0.
- Edges E1..E32 each perform one iteration.
- At E32 (count = 31): outputs are registered, the state goes to DONE and `data_resultRDY` rises.
- Latency: RDY is high in the cycle following E32, i.e. 32 cycles after the capture edge. At E33, RDY falls.
- `busy` is high from after E0 through E32, and low in DONE and IDLE.
- `data_result` and `data_exception` change only at the RUN->DONE edge or on reset.
- Back-to-back use: a start at E33 (during DONE) gives the next RDY after E65. Throughput is one op per 33 cycles.
- Reset asserted mid-RUN: immediately IDLE, outputs 0, no RDY. After deassertion, the first start behaves as if from reset.

## Test plan
- MULT 7 x -3 at E0 -> `data_result` = 0xFFFFFFEB, exception 0, RDY high only in cycle after E32, `busy` high E1..E32.
- MULT 0x00010000 x 0x00010000 -> `data_result` = 0, exception 1. Separately, MULT 0xFFFF8000 x 0x00010000 -> `data_result` = 0x80000000, exception 0.
- DIV -7 / 2 -> `data_result` = 0xFFFFFFFD. DIV 5 / 0 -> result 0, exception 1. DIV 0x80000000 / -1 -> result 0, exception 1.
- Restart: DIV 100/7 at E0, MULT 3 x 4 at E10 -> no RDY after E32, single RDY after E42 with result 12.
- Simultaneous `ctrl_MULT` and `ctrl_DIV` with 6, 3 -> result 18 (multiply).
- `reset` pulsed low at cycle 15 of a MULT -> outputs 0 immediately, no RDY. A subsequent DIV 9/3 gives result 3 with RDY 32 cycles after its start.
